// File: rtl/tc_fetch_pkg.sv
// ============================================================================
// Module  : tc_fetch_pkg
// Brief   : State encoding and length decode shared by the fetch sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tc_fetch_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [2:0] c_LEN_BIAS = 3'd1;

    // instr_len is encoded as (words - 1), so 0..3 maps to 1..4 words.
    function automatic logic [2:0] len_words(input logic [1:0] len);
        return {1'b0, len} + c_LEN_BIAS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tc_fetch_sequencer.sv
// ============================================================================
// Module  : tc_fetch_sequencer
// Brief   : PC owner and 4-word instruction window presenter for the decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_fetch_sequencer
    import tc_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    WORD_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [WORD_WIDTH-1:0] mem_w0,
    input  logic [WORD_WIDTH-1:0] mem_w1,
    input  logic [WORD_WIDTH-1:0] mem_w2,
    input  logic [WORD_WIDTH-1:0] mem_w3,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [WORD_WIDTH-1:0] instr_w0,
    output logic [WORD_WIDTH-1:0] instr_w1,
    output logic [WORD_WIDTH-1:0] instr_w2,
    output logic [WORD_WIDTH-1:0] instr_w3,
    input  logic                  instr_ready,
    input  logic [1:0]            instr_len,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  halt_req,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired
);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CNT_WIDTH-1:0]  r_retired;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_npc;

    assign w_accept = (r_state == VALID) && instr_ready;

    always_comb begin
        w_npc = r_pc;
        if (jump_valid) begin
            w_npc = jump_target;
        end else if (w_accept) begin
            w_npc = r_pc + ADDR_WIDTH'(len_words(instr_len));
        end
    end

    // Memory samples npc on the same edge that loads pc, so the next window
    // lands exactly when pc updates; a stall simply re-reads the same words.
    assign mem_address = rst ? RESET_PC : w_npc;

    assign instr_valid = (r_state == VALID);
    assign halted      = (r_state == HALTED);
    assign instr_pc    = r_pc;
    assign retired     = r_retired;
    assign instr_w0    = mem_w0;
    assign instr_w1    = mem_w1;
    assign instr_w2    = mem_w2;
    assign instr_w3    = mem_w3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FILL;
            r_pc      <= RESET_PC;
            r_retired <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    r_pc    <= w_npc;
                    r_state <= (halt_req && !jump_valid) ? HALTED : VALID;
                end
                VALID: begin
                    r_pc <= w_npc;
                    if (jump_valid) begin
                        r_state <= VALID;
                    end else if (w_accept) begin
                        r_retired <= r_retired + 1'b1;
                        r_state   <= halt_req ? HALTED : VALID;
                    end else if (halt_req) begin
                        r_state <= HALTED;
                    end
                end
                HALTED: begin
                    if (jump_valid) begin
                        r_pc    <= jump_target;
                        r_state <= VALID;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
